// File: rtl/spike_generator.sv
// Time-multiplexed spike generator: each time-unit pulse sweeps the generator memory and emits
// a tagged +1/-1 count for every enabled generator whose tick counter has expired.
// Optional: define SPIKE_GEN_MISS_COUNT_EN to count dropped time-unit pulses.
module spike_generator #(
    parameter int unsigned NGens   = 8,
    parameter int unsigned NPeriod = 16,
    parameter int unsigned NTag    = 11,
    parameter int unsigned NCt     = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NGens-1:0]      conf_gens_used,
    input  logic [2**NGens-1:0]   conf_gens_en,
    input  logic [NGens-1:0]      prog_gen_idx,
    input  logic [NPeriod-1:0]    prog_period,
    input  logic [NPeriod-1:0]    prog_ticks,
    input  logic [NTag-1:0]       prog_tag,
    input  logic                  prog_sign,
    input  logic                  prog_v,
    output logic                  prog_a,
    input  logic                  time_unit_pulse,
    output logic [NTag-1:0]       out_tag,
    output logic [NCt-1:0]        out_ct,
    output logic                  out_v,
    input  logic                  out_a,
    output logic                  busy,
    output logic                  missed_pulse,
    output logic [15:0]           miss_count
);

    localparam int unsigned NEntries = 2**NGens;
    localparam logic [NPeriod-1:0] PeriodOne = NPeriod'(1);
    localparam logic [NGens-1:0]   IdxOne    = NGens'(1);
    localparam logic [NCt-1:0]     CtOne     = NCt'(1);

    typedef struct packed {
        logic [NPeriod-1:0] period;
        logic [NPeriod-1:0] ticks;
        logic [NTag-1:0]    tag;
        logic               sign;
    } entry_t;

    typedef enum logic [1:0] {StIdle, StRead, StEmit, StWrite} state_e;

    entry_t mem [NEntries];

    state_e           state_q, state_d;
    logic [NGens-1:0] idx_q, idx_d;
    entry_t           entry_q, entry_d;
    logic             emit_q, emit_d;
    logic             dec_q, dec_d;
    logic             pending_q, pending_d;
    logic             missed_q, missed_d;
    logic             drop;
    logic             enabled;

    logic             we;
    logic [NGens-1:0] waddr;
    entry_t           wdata;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        entry_d = entry_q;
        emit_d  = emit_q;
        dec_d   = dec_q;
        enabled = 1'b0;
        prog_a  = 1'b0;
        we      = 1'b0;
        waddr   = idx_q;
        wdata   = entry_q;
        unique case (state_q)
            StIdle: begin
                // Programming has priority; a coinciding pulse is held as pending.
                if (prog_v) begin
                    prog_a       = ~reset;
                    we           = 1'b1;
                    waddr        = prog_gen_idx;
                    wdata.period = prog_period;
                    wdata.ticks  = prog_ticks;
                    wdata.tag    = prog_tag;
                    wdata.sign   = prog_sign;
                end else if (time_unit_pulse || pending_q) begin
                    state_d = StRead;
                    idx_d   = '0;
                end
            end
            StRead: begin
                entry_d = mem[idx_q];
                enabled = conf_gens_en[idx_q] && (entry_d.period != '0);
                emit_d  = enabled && (entry_d.ticks == '0);
                dec_d   = enabled && (entry_d.ticks != '0);
                state_d = emit_d ? StEmit : StWrite;
            end
            StEmit: begin
                if (out_a) state_d = StWrite;
            end
            StWrite: begin
                if (emit_q) begin
                    we          = 1'b1;
                    wdata.ticks = entry_q.period - PeriodOne;
                end else if (dec_q) begin
                    we          = 1'b1;
                    wdata.ticks = entry_q.ticks - PeriodOne;
                end
                if (idx_q == conf_gens_used) begin
                    state_d = StIdle;
                end else begin
                    idx_d   = idx_q + IdxOne;
                    state_d = StRead;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A sweep starting from IDLE consumes one pulse; anything beyond one pending pulse is lost.
    always_comb begin
        pending_d = pending_q;
        drop      = 1'b0;
        if (state_q == StIdle && !prog_v) begin
            pending_d = pending_q && time_unit_pulse;
        end else if (time_unit_pulse) begin
            if (pending_q) drop = 1'b1;
            else           pending_d = 1'b1;
        end
        missed_d = missed_q | drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            entry_q   <= '0;
            emit_q    <= 1'b0;
            dec_q     <= 1'b0;
            pending_q <= 1'b0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            entry_q   <= entry_d;
            emit_q    <= emit_d;
            dec_q     <= dec_d;
            pending_q <= pending_d;
            missed_q  <= missed_d;
        end
    end

    // Generator memory survives reset; writes are suppressed while reset is high.
    always_ff @(posedge clk) begin
        if (we && !reset) mem[waddr] <= wdata;
    end

`ifdef SPIKE_GEN_MISS_COUNT_EN
    logic [15:0] miss_count_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            miss_count_q <= '0;
        end else if (drop && miss_count_q != 16'hFFFF) begin
            miss_count_q <= miss_count_q + 16'd1;
        end
    end
    assign miss_count = miss_count_q;
`else
    assign miss_count = '0;
`endif

    assign out_v        = (state_q == StEmit);
    assign out_tag      = entry_q.tag;
    assign out_ct       = entry_q.sign ? '1 : CtOne;
    assign busy         = (state_q != StIdle);
    assign missed_pulse = missed_q;

endmodule

// File: tb/tb_spike_generator.sv
// Directed self-checking bench for spike_generator (default parameters).
module tb_spike_generator;

    localparam int unsigned NGens   = 8;
    localparam int unsigned NPeriod = 16;
    localparam int unsigned NTag    = 11;
    localparam int unsigned NCt     = 9;

    logic                clk = 1'b0;
    logic                reset;
    logic [NGens-1:0]    conf_gens_used;
    logic [2**NGens-1:0] conf_gens_en;
    logic [NGens-1:0]    prog_gen_idx;
    logic [NPeriod-1:0]  prog_period;
    logic [NPeriod-1:0]  prog_ticks;
    logic [NTag-1:0]     prog_tag;
    logic                prog_sign;
    logic                prog_v;
    logic                prog_a;
    logic                time_unit_pulse;
    logic [NTag-1:0]     out_tag;
    logic [NCt-1:0]      out_ct;
    logic                out_v;
    logic                out_a;
    logic                busy;
    logic                missed_pulse;
    logic [15:0]         miss_count;

    int errors = 0;
    int checks = 0;

    spike_generator #(
        .NGens  (NGens),
        .NPeriod(NPeriod),
        .NTag   (NTag),
        .NCt    (NCt)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .conf_gens_used (conf_gens_used),
        .conf_gens_en   (conf_gens_en),
        .prog_gen_idx   (prog_gen_idx),
        .prog_period    (prog_period),
        .prog_ticks     (prog_ticks),
        .prog_tag       (prog_tag),
        .prog_sign      (prog_sign),
        .prog_v         (prog_v),
        .prog_a         (prog_a),
        .time_unit_pulse(time_unit_pulse),
        .out_tag        (out_tag),
        .out_ct         (out_ct),
        .out_v          (out_v),
        .out_a          (out_a),
        .busy           (busy),
        .missed_pulse   (missed_pulse),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic prog_write(input int gi, input int per, input int tk, input int tg,
                              input logic sg);
        @(negedge clk);
        prog_gen_idx = NGens'(gi);
        prog_period  = NPeriod'(per);
        prog_ticks   = NPeriod'(tk);
        prog_tag     = NTag'(tg);
        prog_sign    = sg;
        prog_v       = 1'b1;
        @(negedge clk);
        prog_v       = 1'b0;
    endtask

    task automatic pulse();
        @(negedge clk);
        time_unit_pulse = 1'b1;
        @(negedge clk);
        time_unit_pulse = 1'b0;
    endtask

    // Waits for a sweep to start and finish, counting output transfers.
    task automatic wait_sweep(output int n, output logic [NTag-1:0] first_tag,
                              output logic [NTag-1:0] last_tag, output logic [NCt-1:0] last_ct);
        bit started = 1'b0;
        bit done    = 1'b0;
        n = 0;
        first_tag = '0;
        last_tag  = '0;
        last_ct   = '0;
        for (int i = 0; i < 300; i++) begin
            if (busy) started = 1'b1;
            if (out_v && out_a) begin
                if (n == 0) first_tag = out_tag;
                last_tag = out_tag;
                last_ct  = out_ct;
                n++;
            end
            if (started && !busy) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("sweep_done", 32'(done), 32'd1);
    endtask

    task automatic wait_out_v();
        bit seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_v) begin
                seen = 1'b1;
                break;
            end
        end
        check("out_v_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int n;
        logic [NTag-1:0] ft, lt;
        logic [NCt-1:0]  lc;
        int exp_n [8] = '{1, 0, 0, 0, 1, 0, 0, 0};
        int exp_miss;

`ifdef SPIKE_GEN_MISS_COUNT_EN
        exp_miss = 2;
`else
        exp_miss = 0;
`endif
        reset           = 1'b1;
        conf_gens_used  = '0;
        conf_gens_en    = '0;
        prog_gen_idx    = '0;
        prog_period     = '0;
        prog_ticks      = '0;
        prog_tag        = '0;
        prog_sign       = 1'b0;
        prog_v          = 1'b0;
        time_unit_pulse = 1'b0;
        out_a           = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_v", 32'(out_v), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_prog_a", 32'(prog_a), 32'd0);
        check("rst_missed", 32'(missed_pulse), 32'd0);
        check("rst_miss_count", 32'(miss_count), 32'd0);
        reset = 1'b0;

        // Period-4 generator fires on sweeps 1 and 5.
        for (int g = 0; g < 4; g++) prog_write(g, 0, 0, 0, 1'b0);
        prog_write(3, 4, 0, 'h155, 1'b0);
        conf_gens_used = NGens'(3);
        conf_gens_en   = '0;
        conf_gens_en[3] = 1'b1;
        for (int s = 0; s < 8; s++) begin
            pulse();
            wait_sweep(n, ft, lt, lc);
            check($sformatf("p4_count_s%0d", s + 1), 32'(n), 32'(exp_n[s]));
            if (s == 0 || s == 4) begin
                check($sformatf("p4_tag_s%0d", s + 1), 32'(lt), 32'h155);
                check($sformatf("p4_ct_s%0d", s + 1), 32'(lc), 32'h001);
            end
        end

        // Negative-sign period-1 generator emits every sweep.
        prog_write(0, 1, 0, 'h0AA, 1'b1);
        conf_gens_used = '0;
        conf_gens_en   = '0;
        conf_gens_en[0] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            pulse();
            wait_sweep(n, ft, lt, lc);
            check($sformatf("neg_count_s%0d", s + 1), 32'(n), 32'd1);
            check($sformatf("neg_ct_s%0d", s + 1), 32'(lc), 32'h1FF);
        end

        // Back-pressure stall with programming attempts and overflowing pulses.
        out_a = 1'b0;
        pulse();
        wait_out_v();
        prog_gen_idx = NGens'(5);
        prog_period  = NPeriod'(7);
        prog_v       = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("stall_out_v", 32'(out_v), 32'd1);
            check("stall_tag", 32'(out_tag), 32'h0AA);
            check("stall_ct", 32'(out_ct), 32'h1FF);
            check("stall_busy", 32'(busy), 32'd1);
            check("stall_prog_a", 32'(prog_a), 32'd0);
        end
        pulse();
        check("stall_missed_1", 32'(missed_pulse), 32'd0);
        pulse();
        check("stall_missed_2", 32'(missed_pulse), 32'd1);
        pulse();
        check("stall_miss_count", 32'(miss_count), 32'(exp_miss));
        @(negedge clk);
        prog_v = 1'b0;
        out_a  = 1'b1;
        wait_sweep(n, ft, lt, lc);
        check("stall_release_count", 32'(n), 32'd1);
        wait_sweep(n, ft, lt, lc);
        check("pending_sweep_count", 32'(n), 32'd1);
        check("pending_sweep_tag", 32'(lt), 32'h0AA);
        check("missed_sticky", 32'(missed_pulse), 32'd1);

        // Programming and pulse in the same cycle.
        @(negedge clk);
        prog_gen_idx    = '0;
        prog_period     = NPeriod'(1);
        prog_ticks      = '0;
        prog_tag        = NTag'('h123);
        prog_sign       = 1'b0;
        prog_v          = 1'b1;
        time_unit_pulse = 1'b1;
        #1;
        check("coincide_prog_a", 32'(prog_a), 32'd1);
        @(negedge clk);
        prog_v          = 1'b0;
        time_unit_pulse = 1'b0;
        check("coincide_busy_after", 32'(busy), 32'd0);
        wait_sweep(n, ft, lt, lc);
        check("coincide_count", 32'(n), 32'd1);
        check("coincide_tag", 32'(lt), 32'h123);
        check("coincide_ct", 32'(lc), 32'h001);

        // Reset during EMIT aborts without touching memory.
        prog_write(2, 1, 0, 'h0F0, 1'b1);
        prog_write(3, 1, 0, 'h155, 1'b0);
        conf_gens_used  = NGens'(3);
        conf_gens_en    = '0;
        conf_gens_en[2] = 1'b1;
        conf_gens_en[3] = 1'b1;
        out_a = 1'b0;
        pulse();
        wait_out_v();
        check("pre_reset_tag", 32'(out_tag), 32'h0F0);
        reset        = 1'b1;
        prog_gen_idx = NGens'(2);
        prog_tag     = NTag'('h7FF);
        prog_period  = '0;
        prog_v       = 1'b1;
        @(negedge clk);
        check("mid_rst_out_v", 32'(out_v), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_prog_a", 32'(prog_a), 32'd0);
        check("mid_rst_missed", 32'(missed_pulse), 32'd0);
        check("mid_rst_miss_count", 32'(miss_count), 32'd0);
        reset  = 1'b0;
        prog_v = 1'b0;
        out_a  = 1'b1;
        pulse();
        wait_sweep(n, ft, lt, lc);
        check("post_rst_count", 32'(n), 32'd2);
        check("post_rst_first_tag", 32'(ft), 32'h0F0);
        check("post_rst_last_tag", 32'(lt), 32'h155);
        check("post_rst_last_ct", 32'(lc), 32'h001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spike_generator.md
SPIKE_GENERATOR -- requirements
Module: spike_generator

Interface
REQ-001 The module SHALL have parameter NGens, default 8, meaning the generator index width (2**NGens generators).
REQ-002 The module SHALL have parameter NPeriod, default 16, meaning the period and tick-counter width.
REQ-003 The module SHALL have parameter NTag, default 11, meaning the output tag width.
REQ-004 The module SHALL have parameter NCt, default 9, meaning the output count width.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock.
REQ-006 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The module SHALL have port conf, input, SpikeGeneratorConf bundle: gens_used (max index swept) and gens_en (per-generator enable).
REQ-008 The module SHALL have port prog, input, SpikeGeneratorProgChannel: gen_idx, period, ticks, tag, sign, v in; a out.
REQ-009 The module SHALL have port time_unit_pulse, input, 1 bit: single-cycle wall-clock time-unit strobe.
REQ-010 The module SHALL have port out, output, TagCtChannel: tag, ct, v out; a in.
REQ-011 The module SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-012 The module SHALL have port missed_pulse, output, 1 bit: sticky, set when a time_unit_pulse is dropped.
REQ-013 The module SHALL have port miss_count, output, 16 bits: dropped-pulse count (see Configuration).

Function
REQ-014 A channel transfer SHALL occur on a rising clk edge where v and a are both high; a producer SHALL hold its data stable while v is high and a is low.
REQ-015 Per-generator state SHALL be held in a 2**NGens-entry memory of {period, ticks, tag, sign}.
REQ-016 The FSM SHALL have states IDLE, READ, EMIT and WRITE.
REQ-017 In IDLE, prog.a SHALL be high whenever prog.v is high; each transfer SHALL write the entry at gen_idx, and prog.a SHALL be low in every other state.
REQ-018 A pulse seen in IDLE, or a pending pulse, SHALL start a sweep (IDLE->READ) at index 0; if prog.v and the pulse coincide, the prog write SHALL complete in that cycle and the sweep SHALL start in the next.
REQ-019 READ SHALL fetch entry idx, and the state SHALL go to EMIT if gens_en[idx] is high, period is nonzero and ticks is 0; otherwise it SHALL go to WRITE.
REQ-020 In EMIT, out.v SHALL be high with out.tag equal to the entry tag, and out.ct SHALL be +1 when sign is 0 or all-ones (-1, two's complement) when sign is 1; the state SHALL stay in EMIT until out.a, then go to WRITE.
REQ-021 WRITE SHALL store ticks equal to period-1 if the entry emitted, ticks-1 if it was enabled with nonzero period and ticks > 0, and leave the entry unchanged otherwise.
REQ-022 After WRITE, if idx equals gens_used the state SHALL go to IDLE, else idx SHALL increment and the state SHALL go to READ; idx SHALL never exceed 2**NGens-1.
REQ-023 A pulse arriving while busy SHALL set a pending flag; a pulse arriving while pending is already set SHALL be dropped and SHALL set missed_pulse.
REQ-024 conf SHALL be sampled live, so a change mid-sweep takes effect from the next READ.
REQ-025 A period=1 generator SHALL emit on every swept time unit, and ticks=0 written via prog SHALL emit on the next sweep.

Reset
REQ-026 While reset is high, the FSM SHALL be in IDLE with idx 0, and out.v, prog.a, busy, pending, missed_pulse and miss_count SHALL all be 0.
REQ-027 Reset asserted mid-sweep or mid-EMIT SHALL abort at the next edge and drop out.v, with no partial memory write.
REQ-028 Reset SHALL NOT clear the generator memory; entries SHALL be treated as undefined until programmed.

Configuration
REQ-029 With SPIKE_GEN_MISS_COUNT_EN defined, miss_count SHALL increment, saturating at 0xFFFF, on every dropped pulse.
REQ-030 Without SPIKE_GEN_MISS_COUNT_EN, miss_count SHALL be tied to 0 with no counter logic, while missed_pulse still operates.

Verification
REQ-031 Program gen 3 with period=4, ticks=0, tag=0x155, sign=0, set gens_used=3 and gens_en[3]=1, then apply 8 pulses with out.a=1 -> exactly 2 outputs, on the 1st and 5th sweeps, each with tag 0x155 and ct 0x001.
REQ-032 Program gen 0 with sign=1, period=1, ticks=0, then apply 3 pulses -> 3 outputs with ct 0x1FF.
REQ-033 Hold out.a=0 during EMIT for 10 cycles -> out.v stays high and tag/ct stay stable; busy=1 throughout; prog.a=0 while prog.v=1.
REQ-034 Stall the sweep and apply 3 pulses -> pending is set after the 1st, missed_pulse=1, miss_count=2 (macro on) or 0 (macro off).
REQ-035 Apply prog.v and time_unit_pulse in the same cycle -> the write is acked and the following sweep uses the new entry.
REQ-036 Assert reset during EMIT -> out.v=0 next cycle, FSM in IDLE, and the next pulse sweeps from idx 0.
